// File: rtl/uart_rx_ctrl_if.sv
// Receive stream interface between uart_rx_ctrl and its byte consumer.
//   m_valid : FIFO holds at least one byte
//   m_data  : FIFO head byte (first-word fall-through)
//   m_ready : consumer accepts the head when m_valid & m_ready
interface uart_rx_ctrl_if;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: acknowledges each frame from UART_RX, buffers good
// bytes in a first-word fall-through FIFO, flags overruns and stuck rdrf.
// Optional macro UART_RX_CTRL_FECNT_EN enables the saturating frame-error
// counter; without it fe_cnt is tied to zero.
// Ports:
//   clk, clr   : clock, asynchronous active-low reset
//   rdrf       : data-ready flag from UART_RX
//   rx_data    : received byte, qualified by FE
//   FE         : frame-error flag for rx_data
//   rdrf_clr   : one-cycle acknowledge back to UART_RX
//   m_if       : receive stream (m_valid / m_data / m_ready)
//   ovr        : sticky overrun flag, cleared by ovr_clr
//   ovr_clr    : clears ovr (and fe_cnt when enabled)
//   timeout    : sticky flag, UART_RX held rdrf too long; reset-only clear
//   fe_cnt     : frame-error count
//   fifo_cnt   : FIFO occupancy
module uart_rx_ctrl #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned STALL_TO = 1023
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     rdrf,
   input  logic [7:0]               rx_data,
   input  logic                     FE,
   output logic                     rdrf_clr,
   uart_rx_ctrl_if.master           m_if,
   output logic                     ovr,
   input  logic                     ovr_clr,
   output logic                     timeout,
   output logic [7:0]               fe_cnt,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = 10;

   typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_CLR} state_t;

   state_t          state, state_next;
   logic [TW-1:0]   wait_cnt, wait_cnt_next;
   logic [AW-1:0]   wr_ptr, wr_ptr_next;
   logic [AW-1:0]   rd_ptr, rd_ptr_next;
   logic [CW-1:0]   cnt_next;
   logic            push, pop;
   logic            rdrf_clr_next, ovr_next, timeout_next, m_valid_next;
   logic [7:0]      m_data_next;
   logic [7:0]      mem [DEPTH];

   // Next-state, FIFO bookkeeping and registered-output values
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      push          = 1'b0;
      pop           = m_if.m_valid & m_if.m_ready;
      ovr_next      = ovr & ~ovr_clr;
      timeout_next  = timeout;

      case (state)
         IDLE: begin
            if (rdrf) state_next = CAPTURE;
         end
         CAPTURE: begin
            // set beats clear on ovr, so ovr_next is overridden here
            if (FE)                                          push = 1'b0;
            else if ((fifo_cnt == CW'(DEPTH)) && !pop)       ovr_next = 1'b1;
            else                                             push = 1'b1;
            state_next = ACK;
         end
         ACK: begin
            wait_cnt_next = '0;
            state_next    = WAIT_CLR;
         end
         WAIT_CLR: begin
            if (!rdrf) begin
               state_next = IDLE;
            end else if (wait_cnt >= TW'(STALL_TO)) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end else begin
               wait_cnt_next = wait_cnt + TW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      wr_ptr_next   = push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr_next   = pop  ? rd_ptr + AW'(1) : rd_ptr;
      cnt_next      = fifo_cnt + CW'(push) - CW'(pop);
      rdrf_clr_next = (state_next == ACK);
      m_valid_next  = (cnt_next != '0);

      // Head after this edge: the byte being written if it lands in the head
      // slot, otherwise the stored entry; hold the last value when empty.
      m_data_next = m_if.m_data;
      if (cnt_next != '0) begin
         if (push && (wr_ptr == rd_ptr_next)) m_data_next = rx_data;
         else                                 m_data_next = mem[rd_ptr_next];
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         rdrf_clr     <= 1'b0;
         ovr          <= 1'b0;
         timeout      <= 1'b0;
         m_if.m_valid <= 1'b0;
         m_if.m_data  <= '0;
      end else begin
         state        <= state_next;
         wait_cnt     <= wait_cnt_next;
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         fifo_cnt     <= cnt_next;
         rdrf_clr     <= rdrf_clr_next;
         ovr          <= ovr_next;
         timeout      <= timeout_next;
         m_if.m_valid <= m_valid_next;
         m_if.m_data  <= m_data_next;
      end
   end

   // FIFO storage; push is only possible in CAPTURE, so reset blocks writes
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_data;
   end

`ifdef UART_RX_CTRL_FECNT_EN
   logic       fe_evt;
   logic [7:0] fe_base;

   assign fe_evt = (state == CAPTURE) && FE;

   // ovr_clr zeroes the count first; a same-cycle error then counts as one
   always_comb begin
      fe_base = ovr_clr ? 8'd0 : fe_cnt;
   end

   // Saturating frame-error counter
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)                              fe_cnt <= 8'd0;
      else if (fe_evt && (fe_base != 8'hFF)) fe_cnt <= fe_base + 8'd1;
      else                                   fe_cnt <= fe_base;
   end
`else
   assign fe_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized
// frames, checked every cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned STALL_TO = 12;

   logic       clk = 1'b0;
   logic       clr;
   logic       rdrf;
   logic [7:0] rx_data;
   logic       fe_in;
   logic       rdrf_clr;
   logic       ovr;
   logic       ovr_clr;
   logic       timeout;
   logic [7:0] fe_cnt;
   logic [2:0] fifo_cnt;

   uart_rx_ctrl_if m_if ();

   uart_rx_ctrl #(.DEPTH(DEPTH), .STALL_TO(STALL_TO)) dut (
      .clk      (clk),
      .clr      (clr),
      .rdrf     (rdrf),
      .rx_data  (rx_data),
      .FE       (fe_in),
      .rdrf_clr (rdrf_clr),
      .m_if     (m_if),
      .ovr      (ovr),
      .ovr_clr  (ovr_clr),
      .timeout  (timeout),
      .fe_cnt   (fe_cnt),
      .fifo_cnt (fifo_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   byte unsigned q[$];
   bit           exp_ovr;
   bit           exp_timeout;
   int           exp_fe;
   logic [7:0]   exp_mdata;
   int           ready_mode;   // 0 never, 1 always, 2 random, 3 only at capture
   bit           clr_en;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int fe_expect();
`ifdef UART_RX_CTRL_FECNT_EN
      return exp_fe;
`else
      return 0;
`endif
   endfunction

   task automatic check_outputs(input string tag, input bit exp_clr);
      check({tag, ".rdrf_clr"}, 32'(rdrf_clr),     32'(exp_clr));
      check({tag, ".m_valid"},  32'(m_if.m_valid), 32'(q.size() != 0));
      check({tag, ".fifo_cnt"}, 32'(fifo_cnt),     32'(q.size()));
      check({tag, ".m_data"},   32'(m_if.m_data),  32'(exp_mdata));
      check({tag, ".ovr"},      32'(ovr),          32'(exp_ovr));
      check({tag, ".timeout"},  32'(timeout),      32'(exp_timeout));
      check({tag, ".fe_cnt"},   32'(fe_cnt),       32'(fe_expect()));
   endtask

   function automatic bit rnd_clr();
      return clr_en && ($urandom_range(0, 7) == 0);
   endfunction

   // One clock: model the edge, advance, then compare after the edge.
   task automatic step(input bit cap, input bit exp_clr, input bit do_clr);
      bit pop;
      bit push;
      case (ready_mode)
         0:       m_if.m_ready = 1'b0;
         1:       m_if.m_ready = 1'b1;
         2:       m_if.m_ready = 1'($urandom_range(0, 1));
         default: m_if.m_ready = cap;
      endcase
      ovr_clr = do_clr;
      pop  = (q.size() != 0) && m_if.m_ready;
      push = 1'b0;
      if (do_clr) begin
         exp_ovr = 1'b0;
         exp_fe  = 0;
      end
      if (cap) begin
         if (fe_in)                         exp_fe  = (exp_fe == 255) ? 255 : exp_fe + 1;
         else if (q.size() == DEPTH && !pop) exp_ovr = 1'b1;
         else                               push    = 1'b1;
      end
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(rx_data);
      @(posedge clk);
      #1;
      ovr_clr = 1'b0;
      if (q.size() != 0) exp_mdata = q[0];
      check_outputs(cap ? "cap" : "cyc", exp_clr);
      if (cap) begin
         // data/FE must not be looked at outside CAPTURE
         rx_data = 8'($urandom);
         fe_in   = 1'($urandom);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit fe, input int hold);
      rx_data = b;
      fe_in   = fe;
      rdrf    = 1'b1;
      step(1'b0, 1'b0, rnd_clr());
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, rnd_clr());
      for (int i = 0; i < hold; i++) step(1'b0, 1'b0, rnd_clr());
      rdrf = 1'b0;
      step(1'b0, 1'b0, rnd_clr());
   endtask

   task automatic model_reset();
      q.delete();
      exp_ovr     = 1'b0;
      exp_timeout = 1'b0;
      exp_fe      = 0;
      exp_mdata   = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] drain36 [4];
      clr          = 1'b0;
      rdrf         = 1'b0;
      rx_data      = 8'h00;
      fe_in        = 1'b0;
      ovr_clr      = 1'b0;
      m_if.m_ready = 1'b0;
      ready_mode   = 0;
      clr_en       = 1'b0;
      model_reset();

      // reset values
      #3;
      check_outputs("rst", 1'b0);
      @(posedge clk);
      #1;
      clr = 1'b1;

      // single byte, consumer stalled
      send(8'hA5, 1'b0, 0);
      check("a5.m_data", 32'(m_if.m_data), 32'h0000_00A5);
      check("a5.fifo_cnt", 32'(fifo_cnt), 32'd1);
      ready_mode = 1;
      step(1'b0, 1'b0, 1'b0);

      // overrun with five bytes into a depth-4 FIFO
      ready_mode = 0;
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1);
      check("ovr5.ovr", 32'(ovr), 32'd1);
      check("ovr5.fifo_cnt", 32'(fifo_cnt), 32'd4);
      step(1'b0, 1'b0, 1'b1);
      check("ovr5.cleared", 32'(ovr), 32'd0);
      ready_mode = 1;
      for (int i = 1; i <= 4; i++) begin
         check("ovr5.pop", 32'(m_if.m_data), 32'(i));
         step(1'b0, 1'b0, 1'b0);
      end

      // frame errors are discarded but acknowledged
      ready_mode = 0;
      for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 1'b1, i);
      check("fe3.fifo_cnt", 32'(fifo_cnt), 32'd0);
`ifdef UART_RX_CTRL_FECNT_EN
      check("fe3.fe_cnt", 32'(fe_cnt), 32'd3);
`else
      check("fe3.fe_cnt", 32'(fe_cnt), 32'd0);
`endif

      // full FIFO plus simultaneous pop: no overrun
      for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0, 0);
      ready_mode = 3;
      send(8'h3C, 1'b0, 0);
      check("full.ovr", 32'(ovr), 32'd0);
      check("full.fifo_cnt", 32'(fifo_cnt), 32'd4);
      drain36[0] = 8'h11; drain36[1] = 8'h12; drain36[2] = 8'h13; drain36[3] = 8'h3C;
      ready_mode = 1;
      for (int i = 0; i < 4; i++) begin
         check("full.drain", 32'(m_if.m_data), 32'(drain36[i]));
         step(1'b0, 1'b0, 1'b0);
      end

      // rdrf stuck high after acknowledge
      rx_data = 8'h5A;
      fe_in   = 1'b0;
      rdrf    = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < int'(STALL_TO); i++) step(1'b0, 1'b0, 1'b0);
      exp_timeout = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rdrf = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      check("stall.timeout", 32'(timeout), 32'd1);

      // reset asserted while acknowledging
      ready_mode = 0;
      rx_data    = 8'h77;
      fe_in      = 1'b0;
      rdrf       = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      clr = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_ack", 1'b0);
      #2;
      clr = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rdrf = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      check("rst_ack.recap", 32'(fifo_cnt), 32'd1);

      // randomized traffic
      ready_mode = 2;
      clr_en     = 1'b1;
      for (int n = 0; n < 60; n++) begin
         send(8'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, rnd_clr());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
